// File: rtl/mult_pkg.sv
// mult_pkg: shared multiplier/accumulator types.
package mult_pkg;
   localparam int PROD_W = 4;
   typedef logic [0:PROD_W-1] prod_t;
   typedef enum logic {ACCUM, HOLD} acc_state_t;
endpackage

// File: rtl/product_accumulator_acc_adder.sv
// acc_adder: ACC_W adder with carry-out; PRODUCT_ACC_SAT_EN clamps to all-ones on carry.
module acc_adder
   import mult_pkg::*;
#(
   parameter int ACC_W = 8
) (
   input  logic [0:ACC_W-1]  a,
   input  logic [0:PROD_W-1] b,
   output logic [0:ACC_W-1]  s,
   output logic              c
);
   logic [ACC_W:0] full;
   assign full = (ACC_W+1)'(a) + (ACC_W+1)'(b);
   assign c = full[ACC_W];
`ifdef PRODUCT_ACC_SAT_EN
   assign s = c ? '1 : full[ACC_W-1:0];
`else
   assign s = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums BLOCK_LEN multiplier products per result behind valid/ready.
// Optional saturation selected by PRODUCT_ACC_SAT_EN (see acc_adder).
module product_accumulator
   import mult_pkg::*;
#(
   parameter int ACC_W     = 8,
   parameter int BLOCK_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:PROD_W-1] prod,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:ACC_W-1]  sum,
   output logic              ovf
);
   localparam int CNT_W = $clog2(BLOCK_LEN + 1);
   acc_state_t       state;
   logic [0:ACC_W-1] acc, add_s;
   logic [CNT_W-1:0] cnt;
   logic             ovf_acc, add_c, accept, done;
   acc_adder #(.ACC_W(ACC_W)) u_add (.a(acc), .b(prod), .s(add_s), .c(add_c));
   assign accept = in_valid && in_ready && state == ACCUM;
   assign done = state == ACCUM &&
                 ((accept && cnt == CNT_W'(BLOCK_LEN - 1)) || (flush && (cnt != '0 || accept)));
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf_acc   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         ovf       <= 1'b0;
      end else if (state == ACCUM) begin
         if (done) begin
            sum       <= accept ? add_s : acc;
            ovf       <= ovf_acc | (accept & add_c);
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            state     <= HOLD;
         end else if (accept) begin
            acc     <= add_s;
            cnt     <= cnt + CNT_W'(1);
            ovf_acc <= ovf_acc | add_c;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         state     <= ACCUM;
      end
   end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and randomized checks against a block-sum reference model.
module tb_product_accumulator;
   logic       clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
   logic [0:3] prod = '0;
   logic       in_ready, out_valid, ovf, in_ready_b, out_valid_b, ovf_b;
   logic [0:7] sum;
   logic [0:4] sum_b;
   int         errors = 0, checks = 0;

   always #5 clk = ~clk;

   product_accumulator #(.ACC_W(8), .BLOCK_LEN(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .prod(prod), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf));

   product_accumulator #(.ACC_W(5), .BLOCK_LEN(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .prod(prod), .flush(flush),
      .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b), .ovf(ovf_b));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic put(input int p);
      in_valid = 1;
      prod = 4'(p);
      tick;
      in_valid = 0;
   endtask

   // Reference: a block result is the plain sum of its products, wrapped or clamped at 2^w.
   function automatic int ref_sum(input int total, input int w);
`ifdef PRODUCT_ACC_SAT_EN
      return total >= (1 << w) ? (1 << w) - 1 : total;
`else
      return total % (1 << w);
`endif
   endfunction

   initial begin
      int q[$];
      int total, accepted, cyc, exp_sum, exp_ovf, nres;
      logic busy, acc_now;
      tick; tick;
      rst = 0;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_sum", sum, 0);
      check("reset_ovf", ovf, 0);

      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         check("t1_in_ready", in_ready, 1);
         check("t1_no_early_valid", out_valid, 0);
         put(9);
      end
      check("t1_out_valid", out_valid, 1);
      check("t1_sum", sum, 36);
      check("t1_ovf", ovf, 0);
      check("t1_in_ready_hold", in_ready, 0);
      check("w5_sum", sum_b, ref_sum(36, 5));
      check("w5_ovf", ovf_b, 1);
      tick;
      check("t1_valid_one_cycle", out_valid, 0);
      check("t1_ready_back", in_ready, 1);

      out_ready = 0;
      for (int i = 0; i < 4; i++) put(9);
      in_valid = 1;
      prod = 4'd5;
      for (int i = 0; i < 5; i++) begin
         tick;
         check("t2_hold_sum", sum, 36);
         check("t2_hold_valid", out_valid, 1);
         check("t2_hold_in_ready", in_ready, 0);
      end
      out_ready = 1;
      tick;
      check("t2_released", out_valid, 0);
      check("t2_ready_resume", in_ready, 1);
      out_ready = 0;
      tick;
      in_valid = 0;
      flush = 1;
      tick;
      flush = 0;
      check("t2_single_accept_sum", sum, 5);
      out_ready = 1;
      tick;

      put(3);
      put(4);
      flush = 1;
      tick;
      flush = 0;
      check("t3_flush_valid", out_valid, 1);
      check("t3_flush_sum", sum, 7);
      tick;
      flush = 1;
      tick;
      flush = 0;
      check("t3_empty_flush", out_valid, 0);
      put(3);
      flush = 1;
      put(2);
      flush = 0;
      check("t3_flush_accept_valid", out_valid, 1);
      check("t3_flush_accept_sum", sum, 5);
      tick;

      put(7);
      put(7);
      rst = 1;
      tick;
      rst = 0;
      for (int i = 0; i < 4; i++) put(1);
      check("t5_rst_partial_sum", sum, 4);
      check("t5_rst_partial_valid", out_valid, 1);
      tick;
      out_ready = 0;
      for (int i = 0; i < 4; i++) put(1);
      check("t5_hold_valid", out_valid, 1);
      rst = 1;
      tick;
      rst = 0;
      check("t5_rst_hold_valid", out_valid, 0);
      check("t5_rst_hold_sum", sum, 0);
      check("t5_rst_hold_ready", in_ready, 1);

      busy = 0;
      accepted = 0;
      nres = 0;
      exp_sum = 0;
      exp_ovf = 0;
      cyc = 0;
      while (accepted < 1000 && cyc < 20000) begin
         check("rnd_out_valid", out_valid, busy);
         check("rnd_in_ready", in_ready, !busy);
         if (busy) begin
            check("rnd_sum", sum, exp_sum);
            check("rnd_ovf", ovf, exp_ovf);
         end
         if (!(in_valid && busy)) begin
            in_valid = $urandom_range(0, 3) != 0;
            prod = 4'($urandom_range(0, 15));
         end
         out_ready = $urandom_range(0, 1);
         flush = $urandom_range(0, 9) == 0;
         acc_now = in_valid && !busy;
         if (busy) begin
            if (out_ready) busy = 0;
         end else begin
            if (acc_now) begin
               q.push_back(int'(prod));
               accepted++;
            end
            if (q.size() == 4 || (flush && q.size() > 0)) begin
               total = 0;
               foreach (q[k]) total += q[k];
               exp_sum = ref_sum(total, 8);
               exp_ovf = total > 255;
               q.delete();
               busy = 1;
               nres++;
            end
         end
         tick;
         cyc++;
      end
      check("rnd_products_done", accepted >= 1000, 1);
      check("rnd_results_seen", nres > 250, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
